multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port opcode, input, 6: instruction bits [31:26] from the instruction register.
REQ-004 SHALL have port funct, input, 6: instruction bits [5:0] from the instruction register.
REQ-005 SHALL have port zero, input, 1: ALU compare flag, valid only while aluop=101.
REQ-006 SHALL have port mem_ready, input, 1: memory completes the current access this cycle.
REQ-007 SHALL have ports mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg, alu_src_a, all output, 1: datapath strobes and selects.
REQ-008 SHALL have ports alu_src_b (output, 2) and pc_src (output, 2): ALU B select (00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2) and PC source select (00 ALU, 01 ALUOut, 10 jump target).
REQ-009 SHALL have port aluop, output, 3: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 compare-equal.
REQ-010 SHALL have port illegal, output, 1: one-cycle pulse on unsupported opcode/funct.

Function
REQ-011 SHALL be a Moore FSM: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BEQ, JMP; all outputs decoded from state, mem_ready and zero only.
REQ-012 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-013 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=000, pc_src=00; ir_write=pc_write=mem_ready; stay until mem_ready=1, then DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, aluop=000 (branch target); next by opcode: 0x23/0x2B->MEMADR, 0x00->REX, 0x08->IEX, 0x04->BEQ, 0x02->JMP, other->FETCH with illegal=1.
REQ-015 MEMADR: alu_src_a=1, alu_src_b=10, aluop=000; next MEMRD if opcode=0x23 else MEMWR.
REQ-016 MEMRD: mem_req=1, iord=1, mem_we=0; hold until mem_ready=1, then MEMWB. MEMWR: mem_req=1, iord=1, mem_we=1; hold until mem_ready=1, then FETCH.
REQ-017 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; next FETCH.
REQ-018 REX: alu_src_a=1, alu_src_b=00; aluop by funct: 0x20->000, 0x22->001, 0x24->010, 0x25->011, 0x2A->100; next RWB; unsupported funct -> FETCH, illegal=1, no writeback.
REQ-019 RWB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-020 IEX: alu_src_a=1, alu_src_b=10, aluop=000; next IWB. IWB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-021 BEQ: alu_src_a=1, alu_src_b=00, aluop=101, pc_src=01, pc_write=zero; next FETCH.
REQ-022 JMP: pc_src=10, pc_write=1; next FETCH.
REQ-023 mem_ready SHALL be ignored in every state where mem_req=0; mem_req SHALL remain high continuously until mem_ready is sampled high.
REQ-024 Each output not listed for a state SHALL be 0 in that state; mem_we SHALL never be 1 with mem_req=0.
REQ-025 Cycle counts with mem_ready=1 immediately: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; each wait cycle adds exactly one.

Reset
REQ-026 rst_n low SHALL force state IDLE asynchronously; all outputs 0 within the same cycle, including mid-access (mem_req drops without waiting for mem_ready).
REQ-027 After rst_n rises, first FETCH SHALL occur on the second rising edge.

Configuration
REQ-028 Macro MULTICYCLE_CTRL_INSTRET_EN defined: adds output instret (32) counting completed instructions (entry to FETCH from any state other than IDLE, excluding illegal exits), reset to 0, wraps 0xFFFFFFFF->0.
REQ-029 Macro undefined: no instret port, no counter logic; all other behaviour identical.

Verification
REQ-030 Reset release, mem_ready=1: IDLE 1 cycle, then FETCH with mem_req=1, ir_write=1, pc_write=1, aluop=000.
REQ-031 lw (opcode 0x23), mem_ready low 3 cycles in MEMRD: mem_req/iord held 4 cycles, MEMWB reg_write=1, mem_to_reg=1; total 8 cycles.
REQ-032 R-type funct 0x22 then 0x2A: REX aluop=001 then 100, RWB reg_dst=1, reg_write=1.
REQ-033 beq with zero=1 then zero=0: aluop=101, pc_src=01; pc_write=1 then 0.
REQ-034 opcode 0x3F and R-type funct 0x00: illegal pulses 1 cycle, no reg_write, next state FETCH.
REQ-035 rst_n low during MEMWR wait: mem_req, mem_we drop immediately; after release restart from IDLE; with MULTICYCLE_CTRL_INSTRET_EN, instret=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute and drives datapath strobes.
// Define MULTICYCLE_CTRL_INSTRET_EN to add the 32-bit retired-instruction counter output.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] aluop,
    output logic       illegal
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
        StRex, StRwb, StIex, StIwb, StBeq, StJmp
    } state_t;

    // Write strobes that depend on mem_ready/zero are stored as enables and gated at the output.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_wr_rdy;
        logic       pc_wr_rdy;
        logic       pc_wr_zero;
        logic       pc_wr;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] aluop;
    } ctrl_t;

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       illegal_q, illegal_d;
    logic       armed_q;
    logic       rex_ok;
    logic [2:0] rex_op;
    logic       retire;

    function automatic logic [3:0] rex_decode(input logic [5:0] f);
        unique case (f)
            6'h20:   return {1'b1, 3'b000};
            6'h22:   return {1'b1, 3'b001};
            6'h24:   return {1'b1, 3'b010};
            6'h25:   return {1'b1, 3'b011};
            6'h2A:   return {1'b1, 3'b100};
            default: return {1'b0, 3'b000};
        endcase
    endfunction

    function automatic ctrl_t state_outs(input state_t s, input logic [2:0] op);
        ctrl_t c;
        c = '0;
        unique case (s)
            StFetch: begin
                c.mem_req   = 1'b1;
                c.ir_wr_rdy = 1'b1;
                c.pc_wr_rdy = 1'b1;
                c.alu_src_b = 2'b01;
            end
            StDecode: c.alu_src_b = 2'b11;
            StMemAdr, StIex: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            StMemRd: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            StMemWr: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                c.mem_we  = 1'b1;
            end
            StMemWb: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            StRex: begin
                c.alu_src_a = 1'b1;
                c.aluop     = op;
            end
            StRwb: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            StIwb: c.reg_write = 1'b1;
            StBeq: begin
                c.alu_src_a  = 1'b1;
                c.aluop      = 3'b101;
                c.pc_src     = 2'b01;
                c.pc_wr_zero = 1'b1;
            end
            StJmp: begin
                c.pc_src = 2'b10;
                c.pc_wr  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign {rex_ok, rex_op} = rex_decode(funct);

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        retire    = 1'b0;
        unique case (state_q)
            // Hold IDLE for one full cycle after reset release.
            StIdle:   if (armed_q) state_d = StFetch;
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                unique case (opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StRex;
                    OpAddi:     state_d = StIex;
                    OpBeq:      state_d = StBeq;
                    OpJ:        state_d = StJmp;
                    default: begin
                        state_d   = StFetch;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWr: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StRex: begin
                if (rex_ok) begin
                    state_d = StRwb;
                end else begin
                    state_d   = StFetch;
                    illegal_d = 1'b1;
                end
            end
            StIex: state_d = StIwb;
            StMemWb, StRwb, StIwb, StBeq, StJmp: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        ctrl_d = state_outs(state_d, rex_op);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            armed_q   <= 1'b1;
        end
    end

    assign mem_req    = ctrl_q.mem_req;
    assign mem_we     = ctrl_q.mem_we;
    assign iord       = ctrl_q.iord;
    assign ir_write   = ctrl_q.ir_wr_rdy & mem_ready;
    assign pc_write   = (ctrl_q.pc_wr_rdy & mem_ready) | (ctrl_q.pc_wr_zero & zero) | ctrl_q.pc_wr;
    assign reg_write  = ctrl_q.reg_write;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign pc_src     = ctrl_q.pc_src;
    assign aluop      = ctrl_q.aluop;
    assign illegal    = illegal_q;

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks lw/R/beq/illegal/sw/addi/j and mid-access reset.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg;
    logic       alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] aluop;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic [31:0] instret;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .aluop      (aluop),
        .illegal    (illegal)
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        ,
        .instret    (instret)
`endif
    );

    always #5 clk = ~clk;

    logic [16:0] outs;
    assign outs = {mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg,
                   alu_src_a, alu_src_b, pc_src, aluop, illegal};

    // Expected vector in the same order as outs.
    function automatic logic [16:0] ev(input logic mreq, input logic mwe, input logic io,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic rd, input logic m2r, input logic a,
                                       input logic [1:0] b, input logic [1:0] pcs,
                                       input logic [2:0] op, input logic ill);
        return {mreq, mwe, io, irw, pcw, rw, rd, m2r, a, b, pcs, op, ill};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [16:0] exp);
        #1;
        n_checks++;
        assert (outs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %05h expected %05h", tag, outs, exp);
        end
    endtask

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    task automatic chk_ir(input string tag, input logic [31:0] exp);
        n_checks++;
        assert (instret === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, instret, exp);
        end
    endtask
`endif

    localparam logic [16:0] Zero = 17'h0;

    initial begin
        rst_n = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        chk("reset_outputs", Zero);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("idle_after_release", Zero);
        tick(); chk("idle_first_edge", Zero);
        // lw with three wait cycles in MEMRD
        tick(); opcode = 6'h23;
        chk("fetch_ready", ev(1,0,0,1,1,0,0,0,0,2'b01,2'b00,3'b000,0));
        tick(); chk("lw_decode", ev(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0));
        tick(); chk("lw_memadr", ev(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000,0));
        tick(); mem_ready = 1'b0; chk("lw_memrd_w1", ev(1,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0));
        tick(); chk("lw_memrd_w2", ev(1,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0));
        tick(); chk("lw_memrd_w3", ev(1,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0));
        tick(); mem_ready = 1'b1;
        chk("lw_memrd_done", ev(1,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0));
        tick(); opcode = 6'h00; funct = 6'h22;
        chk("lw_memwb", ev(0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0));
        // R-type sub then slt
        tick(); chk("sub_fetch", ev(1,0,0,1,1,0,0,0,0,2'b01,2'b00,3'b000,0));
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        chk_ir("instret_after_lw", 32'd1);
`endif
        tick(); chk("sub_decode", ev(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0));
        tick(); chk("sub_rex", ev(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b001,0));
        tick(); chk("sub_rwb", ev(0,0,0,0,0,1,1,0,0,2'b00,2'b00,3'b000,0));
        tick(); funct = 6'h2A;
        chk("slt_fetch", ev(1,0,0,1,1,0,0,0,0,2'b01,2'b00,3'b000,0));
        tick(); chk("slt_decode", ev(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0));
        tick(); chk("slt_rex", ev(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b100,0));
        tick(); chk("slt_rwb", ev(0,0,0,0,0,1,1,0,0,2'b00,2'b00,3'b000,0));
        // beq taken then not taken; mem_ready low in DECODE must be ignored
        tick(); opcode = 6'h04; zero = 1'b1;
        chk("beq1_fetch", ev(1,0,0,1,1,0,0,0,0,2'b01,2'b00,3'b000,0));
        tick(); mem_ready = 1'b0;
        chk("beq1_decode", ev(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0));
        tick(); mem_ready = 1'b1;
        chk("beq1_taken", ev(0,0,0,0,1,0,0,0,1,2'b00,2'b01,3'b101,0));
        tick(); zero = 1'b0;
        chk("beq2_fetch", ev(1,0,0,1,1,0,0,0,0,2'b01,2'b00,3'b000,0));
        tick(); chk("beq2_decode", ev(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0));
        tick(); chk("beq2_not_taken", ev(0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b101,0));
        // illegal opcode: pulse lands in the FETCH that follows DECODE
        tick(); opcode = 6'h3F;
        chk("ill_op_fetch", ev(1,0,0,1,1,0,0,0,0,2'b01,2'b00,3'b000,0));
        tick(); chk("ill_op_decode", ev(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0));
        tick(); mem_ready = 1'b0;
        chk("ill_op_pulse", ev(1,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b000,1));
        tick(); mem_ready = 1'b1; opcode = 6'h00; funct = 6'h00;
        chk("ill_op_pulse_end", ev(1,0,0,1,1,0,0,0,0,2'b01,2'b00,3'b000,0));
        // illegal funct: REX visited, no writeback
        tick(); chk("ill_fn_decode", ev(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0));
        tick(); chk("ill_fn_rex", ev(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b000,0));
        tick(); opcode = 6'h2B;
        chk("ill_fn_pulse", ev(1,0,0,1,1,0,0,0,0,2'b01,2'b00,3'b000,1));
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        chk_ir("instret_no_illegal", 32'd5);
`endif
        // sw, then reset while waiting in MEMWR
        tick(); chk("sw_decode", ev(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0));
        tick(); chk("sw_memadr", ev(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000,0));
        tick(); mem_ready = 1'b0;
        chk("sw_memwr_w1", ev(1,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0));
        tick(); chk("sw_memwr_w2", ev(1,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0));
        rst_n = 1'b0;
        chk("reset_mid_access", Zero);
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        chk_ir("instret_reset", 32'd0);
`endif
        tick(); rst_n = 1'b1; mem_ready = 1'b1; opcode = 6'h08;
        chk("idle_after_rerelease", Zero);
        tick(); chk("idle_hold_again", Zero);
        // addi then j
        tick(); chk("addi_fetch", ev(1,0,0,1,1,0,0,0,0,2'b01,2'b00,3'b000,0));
        tick(); chk("addi_decode", ev(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0));
        tick(); chk("addi_iex", ev(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000,0));
        tick(); opcode = 6'h02;
        chk("addi_iwb", ev(0,0,0,0,0,1,0,0,0,2'b00,2'b00,3'b000,0));
        tick(); chk("j_fetch", ev(1,0,0,1,1,0,0,0,0,2'b01,2'b00,3'b000,0));
        tick(); chk("j_decode", ev(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0));
        tick(); chk("j_jmp", ev(0,0,0,0,1,0,0,0,0,2'b00,2'b10,3'b000,0));
        tick(); chk("j_back_to_fetch", ev(1,0,0,1,1,0,0,0,0,2'b01,2'b00,3'b000,0));
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        chk_ir("instret_after_addi_j", 32'd2);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
